fir_decimator: RTL
==================

Name: fir_decimator

Overview:
- Downstream stage of fir_filter. Consumes its 16-bit signed y_out stream and decimates it by DECIM using accumulate-and-dump.
- Each dumped sum is scaled by an arithmetic right shift of SHIFT, rounded, and saturated to OUT_W bits.
- Results are presented on a valid/ready output port with a one-deep holding register, for the next stage or a DAC/packer.

Parameters:
- IN_W, 16, width of signed input sample (matches fir_filter y_out).
- OUT_W, 8, width of signed output sample.
- DECIM, 4, decimation ratio; legal range 2..256.
- SHIFT, 2, arithmetic right shift applied to the dumped sum; legal range 0..IN_W.
- ACC_W (localparam), IN_W+$clog2(DECIM), accumulator width; this width cannot overflow.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- in_data  in  IN_W  signed sample from fir_filter
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- out_data  out  OUT_W  signed decimated sample
- out_valid  out  1  out_data/out_sat valid
- out_ready  in  1  consumer accepts out_data this cycle
- out_sat  out  1  sideband with out_data; 1 = the value was clipped

Behaviour:
- Accept: a sample is accepted when in_valid && in_ready.
- Reset (rst==0 at clk edge): acc=0, phase=0, out_valid=0, out_data=0, out_sat=0. Reset mid-decimation discards the partial sum, and any pending output is dropped.
- phase counter (0..DECIM-1) tracks accepted samples in the current frame. It advances only on accept and wraps DECIM-1 -> 0.
- phase<DECIM-1: on accept, acc <= acc + sext(in_data). in_ready=1 always in this case, including while an output is pending.
- phase==DECIM-1 (dump):
  - in_ready = !out_valid || out_ready. This is combinational from out_ready; no other combinational in->out paths.
  - On accept: sum = acc + sext(in_data); acc <= 0; phase <= 0. The result is loaded into the output register.
- Scaling: r = (sum + RND) >>> SHIFT, computed in ACC_W+1 bits.
  - RND = 1<<(SHIFT-1) when rounding is enabled and SHIFT>0; otherwise RND = 0.
- Saturation:
  - r > 2^(OUT_W-1)-1 -> out_data = max, out_sat=1.
  - r < -2^(OUT_W-1) -> out_data = min, out_sat=1.
  - Otherwise out_data = r[OUT_W-1:0], out_sat=0.
- Latency: out_valid rises on the clk edge that accepts the DECIM-th sample, i.e. it is visible in the following cycle.
- Output handshake:
  - out_data/out_sat are held stable while out_valid && !out_ready.
  - out_valid clears on a transfer unless a new dump is accepted in the same cycle. In that case the register reloads and out_valid stays 1 (back-to-back, no bubble).
- Simultaneous dump accept and output transfer: both occur; the new value replaces the old.
- in_valid=0 stalls the frame indefinitely; acc and phase are held.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: round-half-up (RND = 1<<(SHIFT-1)).
- Undefined: truncation toward -inf (RND=0).
- Saturation and handshake are identical in both builds.

Test Plan:
1. Defaults, out_ready=1, inputs 5,10,15,20 on consecutive cycles -> sum 50. Exactly one output, out_valid for one cycle after the 4th accept: out_data=13 with FIR_DECIM_ROUND_EN, 12 without; out_sat=0.
2. Saturation: four samples of +1000 -> out_data=127, out_sat=1. Then four of -1000 -> out_data=-128, out_sat=1.
3. Negative rounding: inputs -1,-1,-1,-2 (sum -5) -> out_data=-1 with FIR_DECIM_ROUND_EN, -2 without. Inputs -5 x4 -> -5 in both builds.
4. Backpressure:
   - Hold out_ready=0 after the first output (value X). Feed 4 more samples: the first 3 are accepted (in_ready=1); on the 4th, in_ready=0 and out_data stays X.
   - Raise out_ready: X transfers, the 4th sample is accepted that cycle, and the new result appears next cycle with out_valid continuously 1.
5. Reset mid-frame: accept 7,7, pulse rst=0 for one cycle -> out_valid=0, out_data=0. Then feed 4,4,4,4 -> single output 4, no contribution from the 7s.
6. Streaming: 16 consecutive samples of 8 with out_ready=1 -> four outputs of 8, spaced exactly 4 cycles apart. in_valid toggled 1/0 each cycle -> same four values, spaced 8 cycles apart.

Source files
------------

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Downstream stage of fir_filter. Accumulates DECIM accepted input samples,
// then dumps the sum. The sum is arithmetic-right-shifted by SHIFT, optionally
// rounded, saturated to OUT_W bits, and held in a one-deep output register
// behind a valid/ready handshake.
//
// Build option:
//   FIR_DECIM_ROUND_EN  defined   -> round half up before the shift
//                       undefined -> truncate toward -inf (default)
//
// Parameters:
//   IN_W   width of the signed input sample (matches fir_filter y_out)
//   OUT_W  width of the signed output sample
//   DECIM  decimation ratio, 2..256
//   SHIFT  arithmetic right shift applied to the dumped sum, 0..IN_W
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_data    signed input sample
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle
//   out_data   signed decimated sample
//   out_valid  out_data/out_sat valid
//   out_ready  consumer accepts out_data this cycle
//   out_sat    1 = out_data was clipped to the OUT_W range
// -----------------------------------------------------------------------------
module fir_decimator #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DECIM = 4,
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat
);

  // Accumulator is wide enough for DECIM full-scale samples of either sign.
  localparam int ACC_W = IN_W + $clog2(DECIM);
  localparam int PH_W  = $clog2(DECIM);

  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM - 1);

`ifdef FIR_DECIM_ROUND_EN
  localparam int RND_INT = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
`else
  localparam int RND_INT = 0;
`endif

  // Rounding and saturation are evaluated one bit wider than the accumulator
  // so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'(RND_INT);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(1 << (OUT_W - 1)));

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_q,       acc_d;
  logic        [PH_W-1:0]  phase_q,     phase_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q,  out_data_d;
  logic                    out_sat_q,   out_sat_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic is_last;
  logic accept;
  logic dump;
  logic xfer;

  assign is_last = (phase_q == LAST_PHASE);

  // Only the dumping sample needs room in the output register; all other
  // samples go straight into the accumulator. A transfer in the same cycle
  // frees the register, so out_ready feeds in_ready combinationally.
  assign in_ready = !is_last || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign dump     = accept && is_last;
  assign xfer     = out_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Datapath: accumulate, scale, round, saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] in_sext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   scaled;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;

  assign in_sext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
  assign sum     = acc_q + in_sext;
  assign sum_ext = {sum[ACC_W-1], sum};
  assign rounded = sum_ext + RND;
  assign scaled  = rounded >>> SHIFT;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    sat_data = scaled[OUT_W-1:0];
    sat_flag = 1'b0;
    if (scaled > SAT_MAX) begin
      sat_data = OUT_MAX;
      sat_flag = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_data = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      if (is_last) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + PH_W'(1);
      end
    end

    // A dump in the same cycle as a transfer reloads the register and keeps
    // out_valid high, so back-to-back results stream without a bubble.
    if (dump) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_data;
      out_sat_d   = sat_flag;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the accumulator is datapath but is reset too: a reset in the
      // middle of a frame must discard the partial sum, not fold it into the
      // next one.
      acc_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
